// File: rtl/exit_payment_fsm.sv
// Exit payment controller for a 4-spot car park.
// A driver requests exit from an occupied spot. The controller charges a fee of
// elapsed ticks * RATE, saturated at the fee width. It collects coins, returns
// change, opens the door for DOOR_CYCLES cycles, and then pulses a one-hot
// release for the spot.
//
// Ports:
//   CLK, RST                 clock, asynchronous active-low reset
//   exit_req, exit_spot, F   exit request, requested spot, occupancy flags
//   spot0_time..spot3_time   elapsed ticks per spot
//   coin_valid, coin_value   one coin per valid cycle
//   cancel                   abort a payment in progress
//   busy                     high whenever the controller is not idle
//   fee, paid                registered amount due and amount collected
//   change_valid, change     one-cycle change pulse and its amount
//   refund_valid, refund     one-cycle refund pulse and its amount
//   door_open                exit door open
//   spot_release             one-hot, one-cycle pulse that frees the spot
//                            ("release" is a reserved word in SystemVerilog)
//   err                      one-cycle pulse on a request for an empty spot
module exit_payment_fsm #(
  parameter int unsigned TW          = 16,
  parameter int unsigned FEE_W       = 12,
  parameter int unsigned RATE        = 2,
  parameter int unsigned DOOR_CYCLES = 8
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             exit_req,
  input  logic [1:0]       exit_spot,
  input  logic [3:0]       F,
  input  logic [TW-1:0]    spot0_time,
  input  logic [TW-1:0]    spot1_time,
  input  logic [TW-1:0]    spot2_time,
  input  logic [TW-1:0]    spot3_time,
  input  logic             coin_valid,
  input  logic [7:0]       coin_value,
  input  logic             cancel,
  output logic             busy,
  output logic [FEE_W-1:0] fee,
  output logic [FEE_W-1:0] paid,
  output logic             change_valid,
  output logic [FEE_W-1:0] change,
  output logic             refund_valid,
  output logic [FEE_W-1:0] refund,
  output logic             door_open,
  output logic [3:0]       spot_release,
  output logic             err
);

  localparam int unsigned PW = TW + 32;     // product width, cannot overflow
  localparam int unsigned SW = FEE_W + 9;   // paid + coin sum width
  localparam int unsigned CW = $clog2(DOOR_CYCLES + 1);
  localparam logic [FEE_W-1:0] FeeMax = '1;

  typedef enum logic [2:0] {StIdle, StCalc, StPay, StOpen, StRelease} state_e;

  state_e           state_q, state_d;
  logic [1:0]       spot_q, spot_d;
  logic [FEE_W-1:0] fee_q, fee_d, paid_q, paid_d;
  logic [FEE_W-1:0] change_q, change_d, refund_q, refund_d;
  logic             change_valid_q, change_valid_d, refund_valid_q, refund_valid_d;
  logic             err_q, err_d;
  logic [CW-1:0]    door_cnt_q, door_cnt_d;

  logic [TW-1:0]    sel_time;
  logic [PW-1:0]    prod;
  logic [FEE_W-1:0] fee_calc;
  logic [SW-1:0]    sum;
  logic [FEE_W-1:0] paid_sat;

  // The time is selected by the latched spot, never by the live exit_spot.
  always_comb begin
    unique case (spot_q)
      2'd0:    sel_time = spot0_time;
      2'd1:    sel_time = spot1_time;
      2'd2:    sel_time = spot2_time;
      default: sel_time = spot3_time;
    endcase
  end

  always_comb begin
    prod     = PW'(sel_time) * PW'(RATE);
    fee_calc = (prod > PW'(FeeMax)) ? FeeMax : prod[FEE_W-1:0];
    sum      = SW'(paid_q) + SW'(coin_value);
    paid_sat = (sum > SW'(FeeMax)) ? FeeMax : sum[FEE_W-1:0];
  end

  always_comb begin
    state_d        = state_q;
    spot_d         = spot_q;
    fee_d          = fee_q;
    paid_d         = paid_q;
    change_valid_d = 1'b0;
    change_d       = '0;
    refund_valid_d = 1'b0;
    refund_d       = '0;
    err_d          = 1'b0;
    door_cnt_d     = door_cnt_q;

    unique case (state_q)
      StIdle: begin
        if (exit_req) begin
          if (F[exit_spot]) begin
            spot_d  = exit_spot;
            state_d = StCalc;
          end else begin
            err_d = 1'b1;
          end
        end
      end
      StCalc: begin
        fee_d   = fee_calc;
        paid_d  = '0;
        state_d = (fee_calc == '0) ? StOpen : StPay;
      end
      StPay: begin
        // Cancel wins over a same-cycle coin; that coin is dropped.
        if (cancel) begin
          refund_valid_d = 1'b1;
          refund_d       = paid_q;
          state_d        = StIdle;
        end else if (coin_valid) begin
          paid_d = paid_sat;
          if (paid_sat >= fee_q) begin
            change_valid_d = 1'b1;
            change_d       = paid_sat - fee_q;
            state_d        = StOpen;
          end
        end
      end
      StOpen: begin
        if (door_cnt_q == CW'(DOOR_CYCLES - 1)) begin
          door_cnt_d = '0;
          state_d    = StRelease;
        end else begin
          door_cnt_d = door_cnt_q + 1'b1;
        end
      end
      StRelease: state_d = StIdle;
      default:   state_d = StIdle;
    endcase
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_q        <= StIdle;
      spot_q         <= '0;
      fee_q          <= '0;
      paid_q         <= '0;
      change_valid_q <= 1'b0;
      change_q       <= '0;
      refund_valid_q <= 1'b0;
      refund_q       <= '0;
      err_q          <= 1'b0;
      door_cnt_q     <= '0;
    end else begin
      state_q        <= state_d;
      spot_q         <= spot_d;
      fee_q          <= fee_d;
      paid_q         <= paid_d;
      change_valid_q <= change_valid_d;
      change_q       <= change_d;
      refund_valid_q <= refund_valid_d;
      refund_q       <= refund_d;
      err_q          <= err_d;
      door_cnt_q     <= door_cnt_d;
    end
  end

  // State-decoded outputs drop asynchronously with reset.
  always_comb begin
    busy         = (state_q != StIdle);
    door_open    = (state_q == StOpen);
    spot_release = (state_q == StRelease) ? (4'b0001 << spot_q) : 4'b0000;
    fee          = fee_q;
    paid         = paid_q;
    change_valid = change_valid_q;
    change       = change_q;
    refund_valid = refund_valid_q;
    refund       = refund_q;
    err          = err_q;
  end

endmodule

// File: tb/tb_exit_payment_fsm.sv
// Directed bench for exit_payment_fsm with hand-computed expectations.
module tb_exit_payment_fsm;

  logic        CLK = 1'b0;
  logic        RST = 1'b1;
  logic        exit_req = 1'b0;
  logic [1:0]  exit_spot = 2'd0;
  logic [3:0]  F = 4'b0000;
  logic [15:0] spot0_time = '0, spot1_time = '0, spot2_time = '0, spot3_time = '0;
  logic        coin_valid = 1'b0;
  logic [7:0]  coin_value = '0;
  logic        cancel = 1'b0;
  logic        busy, change_valid, refund_valid, door_open, err;
  logic [11:0] fee, paid, change, refund;
  logic [3:0]  spot_release;

  int n_checks = 0;
  int n_fail   = 0;

  exit_payment_fsm dut (
    .CLK          (CLK),
    .RST          (RST),
    .exit_req     (exit_req),
    .exit_spot    (exit_spot),
    .F            (F),
    .spot0_time   (spot0_time),
    .spot1_time   (spot1_time),
    .spot2_time   (spot2_time),
    .spot3_time   (spot3_time),
    .coin_valid   (coin_valid),
    .coin_value   (coin_value),
    .cancel       (cancel),
    .busy         (busy),
    .fee          (fee),
    .paid         (paid),
    .change_valid (change_valid),
    .change       (change),
    .refund_valid (refund_valid),
    .refund       (refund),
    .door_open    (door_open),
    .spot_release (spot_release),
    .err          (err)
  );

  always #5 CLK = ~CLK;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  initial begin
    // Reset state
    #1 RST = 1'b0;
    #2;
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_fee", 32'(fee), 32'd0);
    check("rst_door", 32'(door_open), 32'd0);
    check("rst_release", 32'(spot_release), 32'd0);
    tick();
    tick();
    RST = 1'b1;

    // Normal payment with change; spot index changes after latching
    F = 4'b0100; spot2_time = 16'd5; exit_spot = 2'd2; exit_req = 1'b1;
    tick();
    check("t1_busy_calc", 32'(busy), 32'd1);
    exit_req = 1'b0; exit_spot = 2'd0;
    tick();
    check("t1_fee", 32'(fee), 32'd10);
    check("t1_paid0", 32'(paid), 32'd0);
    coin_valid = 1'b1; coin_value = 8'd4;
    tick();
    check("t1_paid4", 32'(paid), 32'd4);
    tick();
    check("t1_paid8", 32'(paid), 32'd8);
    check("t1_no_change_yet", 32'(change_valid), 32'd0);
    tick();
    coin_valid = 1'b0;
    check("t1_change_valid", 32'(change_valid), 32'd1);
    check("t1_change", 32'(change), 32'd2);
    check("t1_door_first", 32'(door_open), 32'd1);
    for (int i = 1; i < 8; i++) begin
      tick();
      check("t1_door_hold", 32'(door_open), 32'd1);
      check("t1_change_zero", 32'(change), 32'd0);
    end
    tick();
    check("t1_door_closed", 32'(door_open), 32'd0);
    check("t1_release", 32'(spot_release), 32'b0100);
    tick();
    check("t1_release_once", 32'(spot_release), 32'd0);
    check("t1_idle", 32'(busy), 32'd0);
    check("t1_fee_hold", 32'(fee), 32'd10);

    // Request for an empty spot
    F = 4'b0000; exit_spot = 2'd1; exit_req = 1'b1;
    tick();
    exit_req = 1'b0;
    check("t2_err", 32'(err), 32'd1);
    check("t2_busy", 32'(busy), 32'd0);
    tick();
    check("t2_err_once", 32'(err), 32'd0);
    check("t2_busy_after", 32'(busy), 32'd0);
    check("t2_no_release", 32'(spot_release), 32'd0);

    // Cancel together with a coin: coin dropped, refund of what was paid
    F = 4'b0100; spot2_time = 16'd5; exit_spot = 2'd2; exit_req = 1'b1;
    tick();
    exit_req = 1'b0;
    tick();
    check("t3_fee", 32'(fee), 32'd10);
    coin_valid = 1'b1; coin_value = 8'd6;
    tick();
    check("t3_paid6", 32'(paid), 32'd6);
    coin_value = 8'd4; cancel = 1'b1;
    tick();
    coin_valid = 1'b0; cancel = 1'b0;
    check("t3_refund_valid", 32'(refund_valid), 32'd1);
    check("t3_refund", 32'(refund), 32'd6);
    check("t3_paid_no_coin", 32'(paid), 32'd6);
    check("t3_idle", 32'(busy), 32'd0);
    check("t3_door", 32'(door_open), 32'd0);
    tick();
    check("t3_refund_once", 32'(refund_valid), 32'd0);
    check("t3_refund_zero", 32'(refund), 32'd0);

    // Zero fee goes straight to OPEN
    F = 4'b0001; spot0_time = 16'd0; exit_spot = 2'd0; exit_req = 1'b1;
    tick();
    exit_req = 1'b0;
    tick();
    check("t4_fee0", 32'(fee), 32'd0);
    check("t4_open", 32'(door_open), 32'd1);
    check("t4_no_change", 32'(change_valid), 32'd0);
    for (int i = 1; i < 8; i++) tick();
    check("t4_door_last", 32'(door_open), 32'd1);
    tick();
    check("t4_release", 32'(spot_release), 32'b0001);

    // Saturated fee and paid
    tick();
    F = 4'b1000; spot3_time = 16'hFFFF; exit_spot = 2'd3; exit_req = 1'b1;
    tick();
    exit_req = 1'b0;
    tick();
    check("t5_fee_sat", 32'(fee), 32'hFFF);
    coin_valid = 1'b1; coin_value = 8'd255;
    for (int i = 0; i < 16; i++) tick();
    check("t5_paid_4080", 32'(paid), 32'd4080);
    check("t5_still_pay", 32'(door_open), 32'd0);
    tick();
    coin_valid = 1'b0;
    check("t5_paid_sat", 32'(paid), 32'hFFF);
    check("t5_change_valid", 32'(change_valid), 32'd1);
    check("t5_change0", 32'(change), 32'd0);
    for (int i = 0; i < 20; i++) begin
      tick();
      if (spot_release != 4'd0) break;
    end
    check("t5_release", 32'(spot_release), 32'b1000);
    tick();

    // Reset during OPEN
    F = 4'b0001; spot0_time = 16'd0; exit_spot = 2'd0; exit_req = 1'b1;
    tick();
    exit_req = 1'b0;
    tick();
    tick();
    check("t6_open", 32'(door_open), 32'd1);
    #2 RST = 1'b0;
    #1;
    check("t6_door_async", 32'(door_open), 32'd0);
    check("t6_busy_async", 32'(busy), 32'd0);
    tick();
    check("t6_no_release", 32'(spot_release), 32'd0);
    RST = 1'b1;
    F = 4'b0010; spot1_time = 16'd3; exit_spot = 2'd1; exit_req = 1'b1;
    tick();
    exit_req = 1'b0;
    check("t6_accept", 32'(busy), 32'd1);
    tick();
    check("t6_fee", 32'(fee), 32'd6);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/exit_payment_fsm.md
EXIT_PAYMENT_FSM -- requirements
Module: exit_payment_fsm

Interface
REQ-001 SHALL have parameter TW, default 16, meaning the width of the spot occupancy time inputs.
REQ-002 SHALL have parameter FEE_W, default 12, meaning the width of the fee, paid, change and refund values.
REQ-003 SHALL have parameter RATE, default 2, meaning the fee units charged per time tick.
REQ-004 SHALL have parameter DOOR_CYCLES, default 8, meaning the number of cycles the exit door is held open.
REQ-005 SHALL have CLK, input, 1 bit: single clock; all state updates on the rising edge.
REQ-006 SHALL have RST, input, 1 bit: asynchronous, active-low reset.
REQ-007 SHALL have exit_req, input, 1 bit: driver requests exit from the spot on exit_spot.
REQ-008 SHALL have exit_spot, input, 2 bits: spot index 0..3.
REQ-009 SHALL have F, input, 4 bits: spot occupancy flags, bit i high means spot i is occupied.
REQ-010 SHALL have spot0_time..spot3_time, input, TW bits each: elapsed ticks per spot.
REQ-011 SHALL have coin_valid, input, 1 bit, and coin_value, input, 8 bits: one payment per valid cycle.
REQ-012 SHALL have cancel, input, 1 bit: abort the payment in progress.
REQ-013 SHALL have busy, output, 1 bit: high in every state except IDLE.
REQ-014 SHALL have fee and paid, output, FEE_W bits each: registered amount due and registered amount accumulated.
REQ-015 SHALL have change_valid, output, 1 bit, and change, output, FEE_W bits: one-cycle change pulse and its amount.
REQ-016 SHALL have refund_valid, output, 1 bit, and refund, output, FEE_W bits: one-cycle refund pulse on cancel and its amount.
REQ-017 SHALL have door_open, output, 1 bit: exit door open.
REQ-018 SHALL have release, output, 4 bits: one-hot, one-cycle pulse that frees the spot.
REQ-019 SHALL have err, output, 1 bit: one-cycle pulse on an invalid request.

Function
REQ-020 SHALL implement the states IDLE, CALC, PAY, OPEN and RELEASE.
REQ-021 IDLE: on exit_req with F[exit_spot]=1, SHALL latch the spot index and go to CALC.
REQ-022 IDLE: on exit_req with F[exit_spot]=0, SHALL pulse err for 1 cycle and remain in IDLE.
REQ-023 SHALL ignore exit_req in every state other than IDLE.
REQ-024 CALC (1 cycle): SHALL register fee = selected spot_time*RATE, saturated at 2^FEE_W-1, and clear paid.
REQ-025 CALC: SHALL go to OPEN if fee==0, else to PAY.
REQ-026 PAY, on coin_valid: SHALL set paid = paid+coin_value, saturated at 2^FEE_W-1.
REQ-027 PAY: when the updated paid >= fee, SHALL, in the next cycle, pulse change_valid with change = paid-fee and enter OPEN.
REQ-028 PAY: on cancel, SHALL pulse refund_valid with refund = paid and return to IDLE.
REQ-029 PAY: cancel SHALL win over a coin in the same cycle; that coin is not accumulated.
REQ-030 PAY: the next request requires a new exit_req.
REQ-031 OPEN: SHALL assert door_open for exactly DOOR_CYCLES cycles, then go to RELEASE.
REQ-032 OPEN: SHALL ignore cancel and coin_valid.
REQ-033 RELEASE (1 cycle): SHALL pulse release[latched spot] and return to IDLE.
REQ-034 SHALL use the latched spot index throughout, even if exit_spot changes.
REQ-035 SHALL use the spot_time value sampled in CALC and not re-sample it.
REQ-036 change SHALL hold 0 except during the change_valid cycle; refund SHALL hold 0 except during the refund_valid cycle.
REQ-037 fee and paid SHALL hold their values until the next CALC.

Reset
REQ-038 RST low SHALL, asynchronously, force IDLE.
REQ-039 RST low SHALL force all outputs and counters to 0: fee, paid, change, refund, door_open, release, err, busy and the door counter.
REQ-040 Reset mid-operation SHALL abort without a release, change or refund pulse.
REQ-041 After RST rises, the first exit_req SHALL be accepted on the first rising edge.

Verification
REQ-042 F=4'b0100, spot2_time=5, exit_req with spot 2 -> fee=10; coins 4,4,4 -> change_valid with change=2; door_open for 8 cycles; release=4'b0100 for 1 cycle.
REQ-043 F=4'b0000, exit_req with spot 1 -> err pulses for 1 cycle; busy stays 0; no release.
REQ-044 fee=10, coin 6, then cancel together with coin 4 in the same cycle -> refund_valid with refund=6; IDLE; door_open never asserted.
REQ-045 spot0_time=0 -> fee=0; OPEN follows CALC directly; change_valid never asserted; release=4'b0001 pulses.
REQ-046 spot3_time=16'hFFFF -> fee=12'hFFF (saturated); coins accumulate paid to 12'hFFF -> change=0.
REQ-047 RST low during OPEN -> door_open=0 immediately; no release pulse; next exit_req accepted.
